// File: rtl/ms_sched_pkg.sv
// Shared types for the millisecond timer scheduler: command opcodes and
// per-channel run states.
package ms_sched_pkg;

  typedef enum logic [1:0] {
    OP_NOP          = 2'b00,
    OP_ARM_ONESHOT  = 2'b01,
    OP_ARM_PERIODIC = 2'b10,
    OP_CANCEL       = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    CH_IDLE         = 2'b00,
    CH_RUN_ONESHOT  = 2'b01,
    CH_RUN_PERIODIC = 2'b10
  } ch_state_t;

  function automatic logic is_arm_op(input cmd_op_t op);
    return (op == OP_ARM_ONESHOT) || (op == OP_ARM_PERIODIC);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every CLK_DIV clocks,
// high while the count sits at CLK_DIV-1.
module ms_tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk_i,
  input  logic resetn,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          tick_r;

  // Next prescaler value with wrap at CLK_DIV-1.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (cnt_r == CNT_LAST) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CW'(1'b1);
    end
  end

  // Strobe is registered from the next count so it tracks cnt_r == CNT_LAST.
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      cnt_r  <= {CW{1'b0}};
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      tick_r <= (cnt_nxt_s == CNT_LAST);
    end
  end

  assign tick_o = tick_r;

endmodule

// File: rtl/ms_timer_scheduler.sv
// N_CH countdown channels sharing one millisecond tick; one-shot or periodic
// expiry pulses, with commands taking priority over a coincident tick.
module ms_timer_scheduler
  import ms_sched_pkg::*;
#(
  parameter int CLK_DIV = 100000,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_i,
  input  logic             resetn,
  input  logic             cmd_valid_i,
  input  logic [1:0]       cmd_op_i,
  input  logic [CH_W-1:0]  cmd_ch_i,
  input  logic [CNT_W-1:0] cmd_val_i,
  output logic             tick_o,
  output logic [N_CH-1:0]  expire_o,
  output logic [N_CH-1:0]  active_o,
  output logic             err_o
);

  localparam logic [CH_W:0]    N_CH_L  = N_CH[CH_W:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic    tick_s;
  cmd_op_t op_s;
  logic    arm_s;
  logic    ch_ok_s;
  logic    go_s;
  logic    rej_s;
  logic    err_r;

  ms_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk_i (clk_i),
    .resetn(resetn),
    .tick_o(tick_s)
  );

  assign tick_o = tick_s;

  // Command decode: accepted commands go to one channel, rejects only raise err.
  always_comb begin
    op_s    = cmd_op_t'(cmd_op_i);
    arm_s   = is_arm_op(op_s);
    ch_ok_s = ({1'b0, cmd_ch_i} < N_CH_L);
    go_s    = 1'b0;
    rej_s   = 1'b0;
    if (cmd_valid_i && (op_s != OP_NOP)) begin
      if (!ch_ok_s || (arm_s && (cmd_val_i == {CNT_W{1'b0}}))) begin
        rej_s = 1'b1;
      end else begin
        go_s = 1'b1;
      end
    end else begin
      go_s  = 1'b0;
      rej_s = 1'b0;
    end
  end

  // Error pulse for the cycle after a rejected command.
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      err_r <= 1'b0;
    end else begin
      err_r <= rej_s;
    end
  end

  assign err_o = err_r;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    ch_state_t        state_r;
    ch_state_t        state_nxt_s;
    logic [CNT_W-1:0] rem_r;
    logic [CNT_W-1:0] rem_nxt_s;
    logic [CNT_W-1:0] rel_r;
    logic [CNT_W-1:0] rel_nxt_s;
    logic             exp_r;
    logic             exp_nxt_s;
    logic             hit_s;

    assign hit_s = go_s && (cmd_ch_i == CH_W'(i));

    // Channel next state: an addressed command overrides the tick on this channel.
    always_comb begin
      state_nxt_s = state_r;
      rem_nxt_s   = rem_r;
      rel_nxt_s   = rel_r;
      exp_nxt_s   = 1'b0;
      if (hit_s) begin
        case (op_s)
          OP_ARM_ONESHOT: begin
            state_nxt_s = CH_RUN_ONESHOT;
            rem_nxt_s   = cmd_val_i;
            rel_nxt_s   = cmd_val_i;
          end
          OP_ARM_PERIODIC: begin
            state_nxt_s = CH_RUN_PERIODIC;
            rem_nxt_s   = cmd_val_i;
            rel_nxt_s   = cmd_val_i;
          end
          OP_CANCEL: begin
            state_nxt_s = CH_IDLE;
            rem_nxt_s   = {CNT_W{1'b0}};
          end
          default: begin
            state_nxt_s = state_r;
          end
        endcase
      end else if (tick_s && (state_r != CH_IDLE)) begin
        if (rem_r == CNT_ONE) begin
          exp_nxt_s = 1'b1;
          if (state_r == CH_RUN_PERIODIC) begin
            rem_nxt_s = rel_r;
          end else begin
            state_nxt_s = CH_IDLE;
            rem_nxt_s   = {CNT_W{1'b0}};
          end
        end else begin
          rem_nxt_s = rem_r - CNT_ONE;
        end
      end else begin
        exp_nxt_s = 1'b0;
      end
    end

    // Channel registers, including the registered expiry pulse.
    always_ff @(posedge clk_i or negedge resetn) begin
      if (!resetn) begin
        state_r <= CH_IDLE;
        rem_r   <= {CNT_W{1'b0}};
        rel_r   <= {CNT_W{1'b0}};
        exp_r   <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        rem_r   <= rem_nxt_s;
        rel_r   <= rel_nxt_s;
        exp_r   <= exp_nxt_s;
      end
    end

    assign expire_o[i] = exp_r;
    assign active_o[i] = (state_r != CH_IDLE);
  end

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// Randomized bench for ms_timer_scheduler; expected outputs come from an
// absolute-cycle model of tick times and expiry deadlines.
module tb_ms_timer_scheduler;

  localparam int CLK_DIV = 4;
  localparam int N_CH    = 4;
  localparam int CNT_W   = 8;
  localparam int CH_W    = 2;

  logic             clk_i = 1'b0;
  logic             resetn = 1'b0;
  logic             cmd_valid_i = 1'b0;
  logic [1:0]       cmd_op_i = 2'b00;
  logic [CH_W-1:0]  cmd_ch_i = 2'b00;
  logic [CNT_W-1:0] cmd_val_i = 8'h00;
  logic             tick_o;
  logic [N_CH-1:0]  expire_o;
  logic [N_CH-1:0]  active_o;
  logic             err_o;

  ms_timer_scheduler #(
    .CLK_DIV(CLK_DIV),
    .N_CH   (N_CH),
    .CNT_W  (CNT_W),
    .CH_W   (CH_W)
  ) dut (
    .clk_i      (clk_i),
    .resetn     (resetn),
    .cmd_valid_i(cmd_valid_i),
    .cmd_op_i   (cmd_op_i),
    .cmd_ch_i   (cmd_ch_i),
    .cmd_val_i  (cmd_val_i),
    .tick_o     (tick_o),
    .expire_o   (expire_o),
    .active_o   (active_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: mode 0 idle, 1 one-shot, 2 periodic; due = cycle the pulse is visible.
  int mode [N_CH];
  int due  [N_CH];
  int per  [N_CH];
  int err_due;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int first_tick_after(input int c);
    int t;
    t = c + 1;
    while ((t % CLK_DIV) != (CLK_DIV - 1)) t++;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      mode[i] = 0;
      due[i]  = -1;
      per[i]  = 0;
    end
    err_due = -1;
    cyc     = 0;
  endtask

  task automatic check_cycle();
    logic [N_CH-1:0] ee;
    logic [N_CH-1:0] ea;
    for (int i = 0; i < N_CH; i++) begin
      ee[i] = (mode[i] != 0) && (due[i] == cyc);
      ea[i] = (mode[i] != 0) && !((mode[i] == 1) && (due[i] <= cyc));
    end
    check_val("tick", 32'(tick_o), 32'((cyc % CLK_DIV) == (CLK_DIV - 1)));
    check_val("expire", 32'(expire_o), 32'(ee));
    check_val("active", 32'(active_o), 32'(ea));
    check_val("err", 32'(err_o), 32'(err_due == cyc));
    for (int i = 0; i < N_CH; i++) begin
      if ((mode[i] != 0) && (due[i] == cyc)) begin
        if (mode[i] == 1) mode[i] = 0;
        else due[i] = due[i] + per[i] * CLK_DIV;
      end
    end
  endtask

  task automatic model_cmd(input logic v, input int op, input int ch, input int val);
    if (v && (op != 0)) begin
      if ((op == 1) || (op == 2)) begin
        if (val == 0) begin
          err_due = cyc + 1;
        end else begin
          mode[ch] = op;
          per[ch]  = val;
          due[ch]  = first_tick_after(cyc) + CLK_DIV * (val - 1) + 1;
        end
      end else begin
        mode[ch] = 0;
      end
    end
  endtask

  task automatic step(input logic v, input int op, input int ch, input int val);
    cmd_valid_i = v;
    cmd_op_i    = 2'(op);
    cmd_ch_i    = CH_W'(ch);
    cmd_val_i   = CNT_W'(val);
    @(negedge clk_i);
    check_cycle();
    model_cmd(v, op, ch, val);
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(1'b0, 0, 0, 0);
  endtask

  task automatic run_to_expiring_tick(input int ch);
    int b;
    b = 0;
    while (!((mode[ch] != 0) && (due[ch] == cyc + 1)) && (b < 200)) begin
      step(1'b0, 0, 0, 0);
      b++;
    end
    check_val("expiring_tick_bound", 32'(b < 200), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {28'h0, tick_o, err_o, |expire_o, |active_o}, 32'(0));
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_all_zero("reset_outputs");
    resetn = 1'b1;
    model_reset();

    idle(10);

    // One-shot ch0, 3 ms.
    step(1'b1, 1, 0, 3);
    idle(20);

    // Periodic ch1, 2 ms; cancel on the expiring tick.
    step(1'b1, 2, 1, 2);
    idle(20);
    run_to_expiring_tick(1);
    step(1'b1, 3, 1, 0);
    idle(12);

    // Rejected zero-delay arm and a harmless cancel on an idle channel.
    step(1'b1, 1, 2, 0);
    idle(2);
    step(1'b1, 3, 3, 0);
    idle(3);

    // Two one-shots in the same tick interval expire together.
    while ((cyc % CLK_DIV) != 0) step(1'b0, 0, 0, 0);
    step(1'b1, 1, 0, 1);
    step(1'b1, 1, 3, 1);
    idle(6);

    // Re-arm on the expiring tick restarts without a pulse.
    step(1'b1, 1, 0, 2);
    run_to_expiring_tick(0);
    step(1'b1, 1, 0, 5);
    idle(25);

    // Asynchronous reset mid-count on a periodic channel.
    step(1'b1, 2, 2, 3);
    idle(7);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    @(posedge clk_i);
    #1;
    resetn = 1'b1;
    model_reset();
    idle(20);

    // Random command mix.
    for (int k = 0; k < 1500; k++) begin
      if (($urandom % 4) == 0) begin
        step(1'b1, int'($urandom % 4), int'($urandom % N_CH),
             (($urandom % 5) == 0) ? 0 : int'($urandom_range(1, 6)));
      end else begin
        step(1'b0, int'($urandom % 4), int'($urandom % N_CH), int'($urandom_range(0, 6)));
      end
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
